// File: rtl/comparator.sv
// Registered magnitude comparator with 74x85-style cascade inputs.
// Supports unsigned and two's-complement operands. One cycle of latency,
// one result per cycle, no backpressure.
module comparator #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    input  logic             in_valid,
    input  logic             cas_gt,
    input  logic             cas_lt,
    input  logic             cas_eq,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic             out_valid
);

    localparam int unsigned MSB = WIDTH - 1;

    logic             loc_gt;
    logic             loc_lt;
    logic             res_gt;
    logic             res_lt;
    logic             res_eq;
    logic [WIDTH-1:0] res_max;
    logic [WIDTH-1:0] res_min;
    logic             cas_eq_unused;

    // cas_eq is implied when neither cas_gt nor cas_lt is set, so its value never matters
    assign cas_eq_unused = cas_eq;

    // Local compare; in signed mode differing sign bits decide, otherwise the
    // whole-word unsigned compare matches the remaining-bits compare
    always_comb begin
        loc_gt = 1'b0;
        loc_lt = 1'b0;
        if (signed_mode && (A[MSB] != B[MSB])) begin
            loc_gt = ~A[MSB];
            loc_lt = A[MSB];
        end else begin
            loc_gt = (A > B);
            loc_lt = (A < B);
        end
    end

    // Resolve against the cascade inputs (gt > lt > eq priority) and pick max/min
    always_comb begin
        res_gt  = 1'b0;
        res_lt  = 1'b0;
        res_eq  = 1'b0;
        res_max = A;
        res_min = A;
        if (loc_gt) begin
            res_gt  = 1'b1;
            res_max = A;
            res_min = B;
        end else if (loc_lt) begin
            res_lt  = 1'b1;
            res_max = B;
            res_min = A;
        end else if (cas_gt) begin
            res_gt = 1'b1;
        end else if (cas_lt) begin
            res_lt = 1'b1;
        end else begin
            res_eq = 1'b1;
        end
    end

    // Output registers: results update only on accepted inputs, valid pulses one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A_gt_B    <= 1'b0;
            A_lt_B    <= 1'b0;
            A_eq_B    <= 1'b0;
            max_out   <= '0;
            min_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                A_gt_B  <= res_gt;
                A_lt_B  <= res_lt;
                A_eq_B  <= res_eq;
                max_out <= res_max;
                min_out <= res_min;
            end
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: a 1-bit and a 4-bit instance, directed vectors.
module tb_comparator;

    typedef struct {
        string      name;
        logic       gt;
        logic       lt;
        logic       eq;
        logic [3:0] mx;
        logic [3:0] mn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sm = 1'b0;
    logic       cgt = 1'b0;
    logic       clt = 1'b0;
    logic       ceq = 1'b1;

    logic [0:0] a1 = '0, b1 = '0;
    logic       v1 = 1'b0;
    logic       gt1, lt1, eq1, ov1;
    logic [0:0] mx1, mn1;

    logic [3:0] a4 = '0, b4 = '0;
    logic       v4 = 1'b0;
    logic       gt4, lt4, eq4, ov4;
    logic [3:0] mx4, mn4;

    exp_t q1[$];
    exp_t q4[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .signed_mode(sm), .in_valid(v1),
        .cas_gt(cgt), .cas_lt(clt), .cas_eq(ceq),
        .A_gt_B(gt1), .A_lt_B(lt1), .A_eq_B(eq1),
        .max_out(mx1), .min_out(mn1), .out_valid(ov1)
    );

    comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .signed_mode(sm), .in_valid(v4),
        .cas_gt(cgt), .cas_lt(clt), .cas_eq(ceq),
        .A_gt_B(gt4), .A_lt_B(lt4), .A_eq_B(eq4),
        .max_out(mx4), .min_out(mn4), .out_valid(ov4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_entry(input exp_t e, input logic gt, input logic lt, input logic eq,
                             input logic [3:0] mx, input logic [3:0] mn);
        chk({e.name, ".gt"}, 32'(gt), 32'(e.gt));
        chk({e.name, ".lt"}, 32'(lt), 32'(e.lt));
        chk({e.name, ".eq"}, 32'(eq), 32'(e.eq));
        chk({e.name, ".max"}, 32'(mx), 32'(e.mx));
        chk({e.name, ".min"}, 32'(mn), 32'(e.mn));
    endtask

    // Monitor for the 1-bit instance
    always @(negedge clk) begin
        if (rst_n && ov1) begin
            if (q1.size() == 0) begin
                chk("w1.unexpected_valid", 32'(ov1), 32'd0);
            end else begin
                cmp_entry(q1.pop_front(), gt1, lt1, eq1, 4'(mx1), 4'(mn1));
            end
        end
    end

    int ov4_pulses = 0;

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (rst_n && ov4) begin
            ov4_pulses++;
            if (q4.size() == 0) begin
                chk("w4.unexpected_valid", 32'(ov4), 32'd0);
            end else begin
                cmp_entry(q4.pop_front(), gt4, lt4, eq4, mx4, mn4);
            end
        end
    end

    task automatic issue1(input string nm, input logic a, input logic b, input logic s,
                          input logic gt, input logic lt, input logic eq,
                          input logic [3:0] mx, input logic [3:0] mn);
        exp_t e;
        a1 = a; b1 = b; sm = s; cgt = 1'b0; clt = 1'b0; ceq = 1'b1; v1 = 1'b1;
        e.name = nm; e.gt = gt; e.lt = lt; e.eq = eq; e.mx = mx; e.mn = mn;
        q1.push_back(e);
        @(posedge clk); #1;
        v1 = 1'b0;
    endtask

    task automatic issue4(input string nm, input logic [3:0] a, input logic [3:0] b,
                          input logic s, input logic cg, input logic cl, input logic ce,
                          input logic gt, input logic lt, input logic eq,
                          input logic [3:0] mx, input logic [3:0] mn);
        exp_t e;
        a4 = a; b4 = b; sm = s; cgt = cg; clt = cl; ceq = ce; v4 = 1'b1;
        e.name = nm; e.gt = gt; e.lt = lt; e.eq = eq; e.mx = mx; e.mn = mn;
        q4.push_back(e);
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        #12;
        chk("reset.gt", 32'(gt4), 32'd0);
        chk("reset.ov", 32'(ov4), 32'd0);
        chk("reset.max", 32'(mx4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1-bit truth table, back-to-back
        issue1("w1_00", 1'b0, 1'b0, 1'b0, 0, 0, 1, 4'd0, 4'd0);
        issue1("w1_01", 1'b0, 1'b1, 1'b0, 0, 1, 0, 4'd1, 4'd0);
        issue1("w1_10", 1'b1, 1'b0, 1'b0, 1, 0, 0, 4'd1, 4'd0);
        issue1("w1_11", 1'b1, 1'b1, 1'b0, 0, 0, 1, 4'd1, 4'd1);
        issue1("w1_s10", 1'b1, 1'b0, 1'b1, 0, 1, 0, 4'd0, 4'd1);
        repeat (2) @(posedge clk);
        #1;

        // 4-bit: sign handling and cascade priority
        issue4("u8v7", 4'b1000, 4'b0111, 0, 0, 0, 1, 1, 0, 0, 4'd8, 4'd7);
        issue4("s8v7", 4'b1000, 4'b0111, 1, 0, 0, 1, 0, 1, 0, 4'd7, 4'd8);
        issue4("sm3vm5", 4'hD, 4'hB, 1, 0, 0, 1, 1, 0, 0, 4'hD, 4'hB);
        issue4("cas_ignored", 4'd9, 4'd3, 0, 0, 1, 0, 1, 0, 0, 4'd9, 4'd3);
        issue4("cas_gt", 4'h5, 4'h5, 0, 1, 0, 0, 1, 0, 0, 4'h5, 4'h5);
        issue4("cas_lt", 4'h5, 4'h5, 0, 0, 1, 0, 0, 1, 0, 4'h5, 4'h5);
        issue4("cas_eq", 4'h5, 4'h5, 0, 0, 0, 1, 0, 0, 1, 4'h5, 4'h5);
        issue4("cas_none", 4'h5, 4'h5, 0, 0, 0, 0, 0, 0, 1, 4'h5, 4'h5);
        issue4("cas_gtlt", 4'h5, 4'h5, 0, 1, 1, 0, 1, 0, 0, 4'h5, 4'h5);
        issue4("cas_all", 4'h5, 4'h5, 0, 1, 1, 1, 1, 0, 0, 4'h5, 4'h5);
        repeat (2) @(posedge clk);
        #1;

        // Single result followed by three idle cycles: valid pulses once, values hold
        p0 = ov4_pulses;
        issue4("hold_3v9", 4'd3, 4'd9, 0, 0, 0, 1, 0, 1, 0, 4'd9, 4'd3);
        repeat (3) begin
            @(posedge clk); #2;
            chk("hold.ov", 32'(ov4), 32'd0);
            chk("hold.lt", 32'(lt4), 32'd1);
            chk("hold.max", 32'(mx4), 32'd9);
            chk("hold.min", 32'(mn4), 32'd3);
        end
        chk("hold.pulses", 32'(ov4_pulses - p0), 32'd1);

        // Asynchronous reset while a result is valid
        issue4("pre_reset", 4'd12, 4'd4, 0, 0, 0, 1, 1, 0, 0, 4'd12, 4'd4);
        chk("pre_reset.ov", 32'(ov4), 32'd1);
        q4.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.gt", 32'(gt4), 32'd0);
        chk("arst.lt", 32'(lt4), 32'd0);
        chk("arst.eq", 32'(eq4), 32'd0);
        chk("arst.max", 32'(mx4), 32'd0);
        chk("arst.min", 32'(mn4), 32'd0);
        chk("arst.ov", 32'(ov4), 32'd0);
        #3 rst_n = 1'b1;
        issue4("post_reset", 4'd2, 4'd14, 0, 0, 0, 1, 0, 1, 0, 4'd14, 4'd2);
        repeat (3) @(posedge clk);
        #1;

        chk("q1.drained", 32'(q1.size()), 32'd0);
        chk("q4.drained", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comparator.md
# comparator

Registered magnitude comparator with cascade inputs. Compares two WIDTH-bit operands A and B, in unsigned or two's-complement mode, and produces one-hot greater/less/equal flags plus the larger and smaller operand. Cascade inputs let several instances chain into a wider comparator, in the manner of a 74x85. Used as a datapath utility block wherever a clocked compare result is needed.

## Interface
- WIDTH, default 1: operand width in bits, 1 or more.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- signed_mode  input  1  1 treats A and B as two's complement; 0 treats them as unsigned.
- in_valid  input  1  qualifies A, B, signed_mode and the cascade inputs this cycle.
- cas_gt  input  1  cascade-in from the less-significant stage: lower bits greater.
- cas_lt  input  1  cascade-in: lower bits less.
- cas_eq  input  1  cascade-in: lower bits equal. A standalone instance ties cas_eq=1, cas_gt=0, cas_lt=0.
- A_gt_B  output  1  registered: A > B.
- A_lt_B  output  1  registered: A < B.
- A_eq_B  output  1  registered: A == B.
- max_out  output  WIDTH  registered: larger operand, per the active mode.
- min_out  output  WIDTH  registered: smaller operand, per the active mode.
- out_valid  output  1  registered: outputs reflect a newly accepted compare.

## Operation
- Local compare when signed_mode=0: plain unsigned magnitude comparison.
- Local compare when signed_mode=1: the MSB is the sign bit.
  - MSBs differ: the operand with MSB=0 is greater.
  - MSBs equal: compare the remaining bits unsigned.
  - WIDTH=1 signed: 1 represents -1, 0 represents 0.
- If A != B, the local result decides and the cascade inputs are ignored.
- If A == B, the result follows the cascade inputs with priority cas_gt > cas_lt > otherwise equal.
  - A cascade input with no bits set, or with multiple bits set, is resolved by that priority.
- Exactly one of A_gt_B, A_lt_B, A_eq_B is 1 whenever out_valid=1.
- max_out/min_out:
  - A_gt_B: max_out=A, min_out=B.
  - A_lt_B: max_out=B, min_out=A.
  - A_eq_B: both equal A, including when equality was decided by the cascade inputs.
- For chaining, a lower stage's A_gt_B/A_lt_B/A_eq_B drive the next stage's cas_gt/cas_lt/cas_eq.
  - Each stage adds one cycle, so the integrator aligns operand slices with matching delay.
  - Only the most-significant stage may use signed_mode=1.
- in_valid=0: flags, max_out and min_out hold their previous values; out_valid is 0 on the next edge.

## Timing
- Latency: one cycle. Inputs sampled at rising edge N with in_valid=1 appear on the outputs after edge N.
- out_valid=1 for exactly the cycle after each accepting edge. Back-to-back in_valid gives one result per cycle; throughput is 1/cycle.
- No backpressure; outputs are overwritten by the next accepted input.
- Reset: rst_n low immediately forces, independent of clk:
  - A_gt_B=0, A_lt_B=0, A_eq_B=0
  - max_out=0, min_out=0
  - out_valid=0
- Reset asserted mid-operation discards any in-flight result.
- After rst_n deasserts, the first rising edge with in_valid=1 produces the first valid result.
- No combinational path from any input to any output.

## Test plan
- WIDTH=1, unsigned, standalone cascade, in_valid=1, one pair per cycle. Required result one cycle later:
  - (A,B)=(0,0): A_eq_B=1.
  - (0,1): A_lt_B=1, max_out=1, min_out=0.
  - (1,0): A_gt_B=1, max_out=1, min_out=0.
  - (1,1): A_eq_B=1.
- WIDTH=4, A=4'b1000, B=4'b0111:
  - signed_mode=0: A_gt_B=1, max_out=8, min_out=7.
  - signed_mode=1: A_lt_B=1, max_out=4'b0111, min_out=4'b1000.
- WIDTH=4, A=B=4'h5:
  - cas_gt=1: A_gt_B=1.
  - cas_lt=1: A_lt_B=1.
  - cas_eq=1: A_eq_B=1.
  - Cascade inputs with no bits set: A_eq_B=1.
  - cas_gt=cas_lt=1: A_gt_B=1.
- Apply A=3, B=9, then drop in_valid for 3 cycles:
  - out_valid=1 for exactly one cycle.
  - A_lt_B=1, max_out=9, min_out=3 held throughout.
- Drive rst_n low between clock edges while out_valid=1:
  - All outputs go to 0 immediately, without a clock edge.
  - After release, the first accepted compare is correct one cycle later.
